// File: rtl/tutorial_led_blink_pkg.sv
// -----------------------------------------------------------------------------
// tutorial_led_blink_pkg
// Shared definitions for the LED blink-rate selector:
//   - 2-bit select encodings for the four blink rates
//   - half_period(): clocks per half blink period for a given clock and rate
// -----------------------------------------------------------------------------
package tutorial_led_blink_pkg;

    localparam logic [1:0] SEL_100HZ = 2'b00;
    localparam logic [1:0] SEL_50HZ  = 2'b01;
    localparam logic [1:0] SEL_10HZ  = 2'b10;
    localparam logic [1:0] SEL_1HZ   = 2'b11;

    // Number of clock cycles the wave spends high (and then low) per period.
    // The clock is expected to be an exact multiple of twice the blink rate.
    function automatic int unsigned half_period(input int unsigned clk_hz,
                                                input int unsigned blink_hz);
        return clk_hz / (32'd2 * blink_hz);
    endfunction

endpackage

// File: rtl/led_toggle_divider.sv
// -----------------------------------------------------------------------------
// led_toggle_divider
// Free-running divider producing a 50% duty square wave whose period is
// exactly 2*HALF clocks. The toggle first goes high on the HALF-th rising
// edge after reset is released.
//
// Parameters:
//   HALF     - clocks per half period (>= 1)
// Ports:
//   clock    - system clock, rising edge
//   reset    - synchronous active-high reset; clears counter and toggle
//   o_toggle - square wave output (registered)
// -----------------------------------------------------------------------------
module led_toggle_divider #(
    parameter int unsigned HALF = 32'd2
) (
    input  logic clock,
    input  logic reset,
    output logic o_toggle
);

    // A half period of one clock still needs a 1-bit counter to exist.
    localparam int unsigned   CW   = (HALF > 32'd1) ? $clog2(HALF) : 32'd1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 32'd1);
    localparam logic [CW-1:0] ONE  = CW'(32'd1);

    logic [CW-1:0] count_r;
    logic          toggle_r;

    // Count to HALF-1, wrap, and invert the toggle on each wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r  <= '0;
            toggle_r <= 1'b0;
        end else if (count_r == LAST) begin
            count_r  <= '0;
            toggle_r <= ~toggle_r;
        end else begin
            count_r  <= count_r + ONE;
            toggle_r <= toggle_r;
        end
    end

    assign o_toggle = toggle_r;

endmodule

// File: rtl/tutorial_led_blink.sv
// -----------------------------------------------------------------------------
// tutorial_led_blink
// LED blink-rate selector. Four independent dividers generate square waves at
// FREQ_0_HZ..FREQ_3_HZ; the switches pick one and i_enable gates it onto the
// LED pin. The mux and gate are combinational so input changes take effect in
// the same cycle.
//
// Optional build macro:
//   INPUT_SYNC_EN - pass i_enable, i_switch_1, i_switch_2 through two-flop
//                   synchronizers (reset to 0), adding 2 clocks of latency.
//
// Ports:
//   i_clock     - system clock, all state on rising edge
//   i_reset     - synchronous active-high reset
//   i_enable    - 1: LED follows selected wave, 0: LED off
//   i_switch_1  - select MSB
//   i_switch_2  - select LSB
//   o_led_drive - LED drive, active high
// -----------------------------------------------------------------------------
module tutorial_led_blink
    import tutorial_led_blink_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 32'd25_000_000,
    parameter int unsigned FREQ_0_HZ   = 32'd100,
    parameter int unsigned FREQ_1_HZ   = 32'd50,
    parameter int unsigned FREQ_2_HZ   = 32'd10,
    parameter int unsigned FREQ_3_HZ   = 32'd1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_switch_1,
    input  logic i_switch_2,
    output logic o_led_drive
);

    localparam int unsigned HALF_0 = half_period(CLK_FREQ_HZ, FREQ_0_HZ);
    localparam int unsigned HALF_1 = half_period(CLK_FREQ_HZ, FREQ_1_HZ);
    localparam int unsigned HALF_2 = half_period(CLK_FREQ_HZ, FREQ_2_HZ);
    localparam int unsigned HALF_3 = half_period(CLK_FREQ_HZ, FREQ_3_HZ);

    logic [3:0] toggle_s;
    logic       enable_s;
    logic [1:0] select_s;
    logic       wave_s;

    led_toggle_divider #(.HALF(HALF_0)) u_div_0 (
        .clock    (i_clock),
        .reset    (i_reset),
        .o_toggle (toggle_s[0])
    );

    led_toggle_divider #(.HALF(HALF_1)) u_div_1 (
        .clock    (i_clock),
        .reset    (i_reset),
        .o_toggle (toggle_s[1])
    );

    led_toggle_divider #(.HALF(HALF_2)) u_div_2 (
        .clock    (i_clock),
        .reset    (i_reset),
        .o_toggle (toggle_s[2])
    );

    led_toggle_divider #(.HALF(HALF_3)) u_div_3 (
        .clock    (i_clock),
        .reset    (i_reset),
        .o_toggle (toggle_s[3])
    );

`ifdef INPUT_SYNC_EN
    // Bit order in both stages: {enable, switch_1, switch_2}.
    logic [2:0] sync_meta_r;
    logic [2:0] sync_out_r;

    // Two-flop synchronizer for the asynchronous board inputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync_meta_r <= 3'b000;
            sync_out_r  <= 3'b000;
        end else begin
            sync_meta_r <= {i_enable, i_switch_1, i_switch_2};
            sync_out_r  <= sync_meta_r;
        end
    end

    assign enable_s = sync_out_r[2];
    assign select_s = sync_out_r[1:0];
`else
    assign enable_s = i_enable;
    assign select_s = {i_switch_1, i_switch_2};
`endif

    // Rate mux: switching chains does not disturb any counter, so a shortened
    // pulse can appear at the moment of a select change.
    always_comb begin
        wave_s = 1'b0;
        case (select_s)
            SEL_100HZ: wave_s = toggle_s[0];
            SEL_50HZ:  wave_s = toggle_s[1];
            SEL_10HZ:  wave_s = toggle_s[2];
            SEL_1HZ:   wave_s = toggle_s[3];
            default:   wave_s = 1'b0;
        endcase
    end

    assign o_led_drive = enable_s & wave_s;

endmodule

// File: tb/tb_tutorial_led_blink.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_tutorial_led_blink
// Self-checking bench for tutorial_led_blink at CLK_FREQ_HZ=200, giving half
// periods of 1, 2, 10 and 100 clocks. A reference model (edge count since
// reset release, divided by the half period) pushes the expected LED value to
// a scoreboard queue each cycle; the value is popped and compared on the
// falling edge. A table of stimulus rows plus hand sequences cover select
// changes, mid-period reset and enable latency.
// -----------------------------------------------------------------------------
module tb_tutorial_led_blink;

`ifdef INPUT_SYNC_EN
    localparam int LAT      = 2;
    localparam int FIRST_00 = 3;
`else
    localparam int LAT      = 0;
    localparam int FIRST_00 = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic sw1;
    logic sw2;
    logic led;

    tutorial_led_blink #(
        .CLK_FREQ_HZ (32'd200),
        .FREQ_0_HZ   (32'd100),
        .FREQ_1_HZ   (32'd50),
        .FREQ_2_HZ   (32'd10),
        .FREQ_3_HZ   (32'd1)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_enable    (en),
        .i_switch_1  (sw1),
        .i_switch_2  (sw2),
        .o_led_drive (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  exp;
        string tag;
    } sb_t;

    typedef struct {
        logic       en;
        logic [1:0] sel;
        int         cycles;
        int         first_hi;   // edge of first high sample, -1 = never
        int         ones;       // high samples counted over edges > 2
        string      name;
    } vec_t;

    int   half_tab [4] = '{1, 2, 10, 100};
    sb_t  sb_q [$];
    int   e_cnt;
    logic [2:0] p1;
    logic [2:0] p2;
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, e_cnt);
        end
    endtask

    // One clock: drive inputs, model the edge, push expectation, compare on negedge.
    task automatic step(input logic r, input logic e_in, input logic [1:0] s_in,
                        input string tag);
        sb_t        item;
        logic       eff_en;
        logic [1:0] eff_sel;
        logic       tog;
        rst = r;
        en  = e_in;
        {sw1, sw2} = s_in;
        @(posedge clk);
        if (r) begin
            e_cnt = 0;
            p1 = 3'b000;
            p2 = 3'b000;
        end else begin
            e_cnt++;
            p2 = p1;
            p1 = {e_in, s_in};
        end
`ifdef INPUT_SYNC_EN
        {eff_en, eff_sel} = p2;
`else
        {eff_en, eff_sel} = {e_in, s_in};
`endif
        tog = ((e_cnt / half_tab[eff_sel]) % 2) == 1;
        item.exp = eff_en & tog;
        item.tag = tag;
        sb_q.push_back(item);
        @(negedge clk);
        item = sb_q.pop_front();
        check(item.tag, int'(led), int'(item.exp));
    endtask

    task automatic do_reset(input logic e_in, input logic [1:0] s_in);
        for (int i = 0; i < 3; i++) step(1'b1, e_in, s_in, "reset");
    endtask

    task automatic run(input logic e_in, input logic [1:0] s_in, input int n,
                       input string tag, output int first_hi, output int ones);
        first_hi = -1;
        ones     = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, e_in, s_in, tag);
            if (led === 1'b1) begin
                if (first_hi < 0) first_hi = e_cnt;
                if (e_cnt > 2) ones++;
            end
        end
    endtask

    vec_t vecs [6];

    initial begin
        int fh;
        int ones;
        int lat;
        n_checks = 0;
        n_fail   = 0;
        e_cnt    = 0;
        p1       = 3'b000;
        p2       = 3'b000;
        rst = 1'b1;
        en  = 1'b0;
        sw1 = 1'b0;
        sw2 = 1'b0;

        vecs[0] = '{1'b0, 2'b11, 300, -1,       0,   "off_300"};
        vecs[1] = '{1'b1, 2'b00, 8,   FIRST_00, 3,   "rate_100hz"};
        vecs[2] = '{1'b1, 2'b01, 12,  2,        5,   "rate_50hz"};
        vecs[3] = '{1'b1, 2'b10, 40,  10,       20,  "rate_10hz"};
        vecs[4] = '{1'b1, 2'b11, 250, 100,      100, "rate_1hz"};
        vecs[5] = '{1'b0, 2'b00, 20,  -1,       0,   "off_100hz"};

        for (int v = 0; v < 6; v++) begin
            do_reset(vecs[v].en, vecs[v].sel);
            check({vecs[v].name, "_reset"}, int'(led), 0);
            run(vecs[v].en, vecs[v].sel, vecs[v].cycles, vecs[v].name, fh, ones);
            check({vecs[v].name, "_first_hi"}, fh, vecs[v].first_hi);
            check({vecs[v].name, "_ones"}, ones, vecs[v].ones);
        end

        // Select change 11 -> 00 after edge 36; 1 Hz chain must still rise at 100.
        do_reset(1'b1, 2'b11);
        run(1'b1, 2'b11, 36, "sw_pre", fh, ones);
        check("sw_pre_first_hi", fh, -1);
        run(1'b1, 2'b00, 59, "sw_100hz", fh, ones);
        check("sw_100hz_first_hi", fh, 37 + LAT);
        run(1'b1, 2'b11, 10, "sw_back_1hz", fh, ones);
        check("sw_back_1hz_first_hi", fh, 100);

        // Reset pulse at edge 56 while the 10 Hz wave is high.
        do_reset(1'b1, 2'b10);
        run(1'b1, 2'b10, 55, "mid_pre", fh, ones);
        check("mid_pre_high", int'(led), 1);
        step(1'b1, 1'b1, 2'b10, "mid_reset");
        check("mid_reset_low", int'(led), 0);
        run(1'b1, 2'b10, 25, "mid_post", fh, ones);
        check("mid_post_first_hi", fh, 10);

        // Enable step while the 1 Hz wave is high: latency in clocks.
        do_reset(1'b0, 2'b11);
        run(1'b0, 2'b11, 120, "en_pre", fh, ones);
        en = 1'b1;
        #1;
        lat = (led === 1'b1) ? 0 : -1;
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b1, 2'b11, "en_step");
            if (lat < 0 && led === 1'b1) lat = k;
        end
        check("enable_latency", lat, LAT);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
